// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the multiplexed 7-segment scan decoder: segment
// patterns (abcdefg, 1 = lit), special digit codes and FSM encoding.
package seg_scan_decoder_pkg;

  localparam int NUM_DIGITS = 5;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_BAD   = 4'hE;

  typedef enum logic {
    ST_SETTLING = 1'b0,
    ST_HOLD     = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_scan_decoder_seg7_decode.sv
// Combinational inverse of the display digit encoder: abcdefg pattern to
// BCD value. Only exact table matches are valid.
module seg7_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       valid
);

  always_comb begin
    value = DIGIT_BAD;
    valid = 1'b1;
    case (pattern)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: value = DIGIT_BLANK;
      default: begin
        value = DIGIT_BAD;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed 5-digit 7-segment display, captures each stable
// digit selection once, and publishes whole frames with a one-cycle pulse.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter bit CAT_ACTIVE_LOW = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  segments,
  input  logic [4:0]  cathodes,
  output logic [19:0] digits,
  output logic [4:0]  dp,
  output logic        frame_valid,
  output logic        decode_err,
  output logic        no_signal
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam int         TO_W        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [12:0] sync1, sync2, pat, prev;
  logic [7:0]  settle_cnt;
  logic        changed, settled;
  scan_state_t state, state_next;
  logic        fire, one_hot, multi_hot, capture;
  logic [4:0]  sel;
  logic [7:0]  seg_in;
  logic [3:0]  dec_value;
  logic        dec_valid;
  logic [19:0] stage_digits;
  logic [4:0]  stage_dp;
  logic [4:0]  seen;
  logic [TO_W-1:0] to_cnt;

  // Both buses are asynchronous to clk; polarity is normalised after the
  // synchroniser so everything downstream treats 1 as selected / lit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {segments, cathodes};
      sync2 <= sync1;
      prev  <= pat;
    end
  end

  assign pat     = {sync2[12:5] ^ {8{SEG_ACTIVE_LOW}}, sync2[4:0] ^ {5{CAT_ACTIVE_LOW}}};
  assign changed = (pat != prev);
  assign settled = !changed && (settle_cnt == SETTLE_LAST);
  assign seg_in  = pat[12:5];
  assign sel     = pat[4:0];

  always_ff @(posedge clk) begin
    if (!reset_n)               settle_cnt <= '0;
    else if (changed)           settle_cnt <= '0;
    else if (settle_cnt != 8'hFF) settle_cnt <= settle_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_SETTLING;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_SETTLING: if (settled) state_next = ST_HOLD;
      ST_HOLD:     if (changed) state_next = ST_SETTLING;
      default:     state_next = ST_SETTLING;
    endcase
  end

  // Capture fires only on the SETTLING -> HOLD edge: once per stable interval.
  always_comb begin
    fire      = (state == ST_SETTLING) && settled;
    one_hot   = $onehot(sel);
    multi_hot = (sel != 5'b0) && !one_hot;
    capture   = fire && one_hot;
  end

  seg7_decode u_decode (
    .pattern (seg_in[7:1]),
    .value   (dec_value),
    .valid   (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_digits <= '0;
      stage_dp     <= '0;
      seen         <= '0;
      to_cnt       <= '0;
      digits       <= '0;
      dp           <= '0;
      frame_valid  <= 1'b0;
      decode_err   <= 1'b0;
      no_signal    <= 1'b1;
    end else begin
      frame_valid <= 1'b0;
      decode_err  <= fire && (multi_hot || (one_hot && !dec_valid));
      if (capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            stage_digits[4*i +: 4] <= dec_value;
            stage_dp[i]            <= seg_in[0];
          end
        end
        seen      <= seen | sel;
        to_cnt    <= '0;
        no_signal <= 1'b0;
      end else begin
        // A completed frame is always published the cycle after its last
        // capture, so it can never coincide with a timeout expiry.
        if (seen == 5'b11111) begin
          digits      <= stage_digits;
          dp          <= stage_dp;
          frame_valid <= 1'b1;
          seen        <= '0;
        end else if (to_cnt == TO_LAST) begin
          no_signal <= 1'b1;
          seen      <= '0;
        end
        if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: display loopback scans, capture
// latency, settle/blank/multi-hot handling, timeout and mid-frame reset.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  segments;
  logic [4:0]  cathodes;
  logic [19:0] digits;
  logic [4:0]  dp;
  logic        frame_valid;
  logic        decode_err;
  logic        no_signal;

  int total = 0;
  int bad   = 0;
  int fv_count = 0;
  int derr_count = 0;
  logic [19:0] last_digits = '0;
  logic [4:0]  last_dp = '0;

  seg_scan_decoder #(
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (200),
    .CAT_ACTIVE_LOW (1'b0),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .segments    (segments),
    .cathodes    (cathodes),
    .digits      (digits),
    .dp          (dp),
    .frame_valid (frame_valid),
    .decode_err  (decode_err),
    .no_signal   (no_signal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_count++;
      last_digits = digits;
      last_dp     = dp;
    end
    if (decode_err === 1'b1) derr_count++;
  end

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic drive(input logic [4:0] cat, input logic [7:0] seg, input int n);
    @(posedge clk); #1;
    cathodes = cat;
    segments = seg;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic show_digit(input int i, input logic [7:0] seg);
    drive(5'(1 << i), seg, 24);
    drive(5'b0, 8'h00, 4);
  endtask

  task automatic show_val(input int i, input int v, input logic d);
    show_digit(i, {seg_of(v), d});
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    cathodes = 5'b0;
    segments = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    total++; if (digits !== 20'h0) begin bad++; $display("FAIL reset_digits: got %h want 00000", digits); end
    total++; if (dp !== 5'b0) begin bad++; $display("FAIL reset_dp: got %b want 00000", dp); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    total++; if (decode_err !== 1'b0) begin bad++; $display("FAIL reset_derr: got %b want 0", decode_err); end
    total++; if (no_signal !== 1'b1) begin bad++; $display("FAIL reset_nosig: got %b want 1", no_signal); end
  endtask

  task automatic test_loopback;
    int f0, e0;
    for (int p = 0; p < 2; p++) begin
      f0 = fv_count;
      e0 = derr_count;
      for (int i = 0; i < 5; i++) show_val(i, i + 1, (i == 1) || (i == 3));
      @(negedge clk);
      total++; if (fv_count != f0 + 1) begin bad++; $display("FAIL loop_fv_count: got %0d want %0d", fv_count - f0, 1); end
      total++; if (last_digits !== 20'h54321) begin bad++; $display("FAIL loop_digits: got %h want 54321", last_digits); end
      total++; if (last_dp !== 5'b01010) begin bad++; $display("FAIL loop_dp: got %b want 01010", last_dp); end
      total++; if (derr_count != e0) begin bad++; $display("FAIL loop_derr: got %0d want 0", derr_count - e0); end
      total++; if (no_signal !== 1'b0) begin bad++; $display("FAIL loop_nosig: got %b want 0", no_signal); end
    end
  endtask

  task automatic test_latency;
    int f0;
    f0 = fv_count;
    for (int i = 0; i < 4; i++) show_val(i, i + 1, (i == 1) || (i == 3));
    @(posedge clk); #1;
    cathodes = 5'b10000;
    segments = {seg_of(5), 1'b0};
    repeat (19) @(posedge clk);
    @(negedge clk);
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got %b want 0", frame_valid); end
    @(posedge clk);
    @(negedge clk);
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL lat_pulse: got %b want 1", frame_valid); end
    drive(5'b0, 8'h00, 4);
    @(negedge clk);
    total++; if (fv_count != f0 + 1) begin bad++; $display("FAIL lat_count: got %0d want 1", fv_count - f0); end
    total++; if (last_digits !== 20'h54321) begin bad++; $display("FAIL lat_digits: got %h want 54321", last_digits); end
    total++; if (last_dp !== 5'b01010) begin bad++; $display("FAIL lat_dp: got %b want 01010", last_dp); end
  endtask

  task automatic test_short_hold;
    int f0;
    f0 = fv_count;
    drive(5'b00100, {7'b0110011, 1'b0}, 10);
    drive(5'b0, 8'h00, 4);
    show_val(0, 1, 1'b0);
    show_val(1, 2, 1'b0);
    show_val(3, 4, 1'b0);
    show_val(4, 5, 1'b0);
    @(negedge clk);
    total++; if (fv_count != f0) begin bad++; $display("FAIL short_no_frame: got %0d want 0", fv_count - f0); end
    show_val(2, 7, 1'b0);
    @(negedge clk);
    total++; if (fv_count != f0 + 1) begin bad++; $display("FAIL short_frame: got %0d want 1", fv_count - f0); end
    total++; if (last_digits !== 20'h54721) begin bad++; $display("FAIL short_digits: got %h want 54721", last_digits); end
  endtask

  task automatic test_multi_hot;
    int f0, e0;
    f0 = fv_count;
    e0 = derr_count;
    show_val(2, 3, 1'b0);
    show_val(3, 4, 1'b1);
    show_val(4, 5, 1'b0);
    drive(5'b00011, {seg_of(8), 1'b0}, 20);
    drive(5'b0, 8'h00, 4);
    @(negedge clk);
    total++; if (derr_count != e0 + 1) begin bad++; $display("FAIL multi_derr: got %0d want 1", derr_count - e0); end
    total++; if (fv_count != f0) begin bad++; $display("FAIL multi_no_frame: got %0d want 0", fv_count - f0); end
    show_val(0, 9, 1'b0);
    @(negedge clk);
    total++; if (fv_count != f0) begin bad++; $display("FAIL multi_mask: got %0d want 0", fv_count - f0); end
    show_val(1, 6, 1'b1);
    @(negedge clk);
    total++; if (fv_count != f0 + 1) begin bad++; $display("FAIL multi_frame: got %0d want 1", fv_count - f0); end
    total++; if (last_digits !== 20'h54369) begin bad++; $display("FAIL multi_digits: got %h want 54369", last_digits); end
    total++; if (last_dp !== 5'b01010) begin bad++; $display("FAIL multi_dp: got %b want 01010", last_dp); end
  endtask

  task automatic test_bad_pattern;
    int f0, e0;
    f0 = fv_count;
    e0 = derr_count;
    show_digit(0, {7'b1000001, 1'b0});
    @(negedge clk);
    total++; if (derr_count != e0 + 1) begin bad++; $display("FAIL bad_derr: got %0d want 1", derr_count - e0); end
    show_digit(1, 8'h00);
    @(negedge clk);
    total++; if (derr_count != e0 + 1) begin bad++; $display("FAIL blank_derr: got %0d want 1", derr_count - e0); end
    show_val(2, 0, 1'b0);
    show_val(3, 8, 1'b1);
    show_val(4, 9, 1'b0);
    @(negedge clk);
    total++; if (fv_count != f0 + 1) begin bad++; $display("FAIL bad_frame: got %0d want 1", fv_count - f0); end
    total++; if (last_digits !== 20'h980FE) begin bad++; $display("FAIL bad_digits: got %h want 980fe", last_digits); end
    total++; if (last_dp !== 5'b01000) begin bad++; $display("FAIL bad_dp: got %b want 01000", last_dp); end
  endtask

  task automatic test_timeout;
    int f0;
    f0 = fv_count;
    @(negedge clk);
    total++; if (no_signal !== 1'b0) begin bad++; $display("FAIL to_start: got %b want 0", no_signal); end
    show_val(0, 1, 1'b0);
    show_val(1, 2, 1'b0);
    show_val(2, 3, 1'b0);
    @(posedge clk); #1;
    cathodes = 5'b01000;
    segments = {seg_of(4), 1'b0};
    repeat (218) @(posedge clk);
    @(negedge clk);
    total++; if (no_signal !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", no_signal); end
    @(posedge clk);
    @(negedge clk);
    total++; if (no_signal !== 1'b1) begin bad++; $display("FAIL to_rise: got %b want 1", no_signal); end
    drive(5'b0, 8'h00, 4);
    show_val(4, 5, 1'b0);
    @(negedge clk);
    total++; if (no_signal !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", no_signal); end
    total++; if (fv_count != f0) begin bad++; $display("FAIL to_no_frame: got %0d want 0", fv_count - f0); end
    for (int i = 0; i < 4; i++) show_val(i, i + 6, 1'b0);
    @(negedge clk);
    total++; if (fv_count != f0 + 1) begin bad++; $display("FAIL to_frame: got %0d want 1", fv_count - f0); end
    total++; if (last_digits !== 20'h59876) begin bad++; $display("FAIL to_digits: got %h want 59876", last_digits); end
  endtask

  task automatic test_reset_mid_frame;
    int f0;
    show_val(0, 1, 1'b0);
    show_val(1, 2, 1'b0);
    show_val(2, 3, 1'b0);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    total++; if (digits !== 20'h0) begin bad++; $display("FAIL mid_digits: got %h want 00000", digits); end
    total++; if (dp !== 5'b0) begin bad++; $display("FAIL mid_dp: got %b want 00000", dp); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL mid_fv: got %b want 0", frame_valid); end
    total++; if (decode_err !== 1'b0) begin bad++; $display("FAIL mid_derr: got %b want 0", decode_err); end
    total++; if (no_signal !== 1'b1) begin bad++; $display("FAIL mid_nosig: got %b want 1", no_signal); end
    f0 = fv_count;
    show_val(3, 4, 1'b0);
    show_val(4, 5, 1'b1);
    @(negedge clk);
    total++; if (fv_count != f0) begin bad++; $display("FAIL mid_partial: got %0d want 0", fv_count - f0); end
    show_val(0, 6, 1'b0);
    show_val(1, 7, 1'b0);
    show_val(2, 8, 1'b0);
    @(negedge clk);
    total++; if (fv_count != f0 + 1) begin bad++; $display("FAIL mid_frame: got %0d want 1", fv_count - f0); end
    total++; if (last_digits !== 20'h54876) begin bad++; $display("FAIL mid_frame_digits: got %h want 54876", last_digits); end
    total++; if (last_dp !== 5'b10000) begin bad++; $display("FAIL mid_frame_dp: got %b want 10000", last_dp); end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_latency;
    test_short_hold;
    test_multi_hot;
    test_bad_pattern;
    test_timeout;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
